// File: rtl/rv32_mem_stage.sv
// Memory stage: B/H/W loads and stores over a req/gnt + rvalid bus, one access outstanding; 1-cycle for non-mem ops and granted stores.
// Loads stall upstream until rvalid. A response that arrives under stop is parked in HOLD until stop falls.
package rv32_mem_pkg;
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
  } decoded_instr_t;

  typedef struct packed {
    logic [31:0]    instr;
    logic [31:0]    pc;
    decoded_instr_t decoded_instr;
    logic [31:0]    mem_addr;
    logic [31:0]    wb_result;
  } exec_mem_buffer_t;

  typedef struct packed {
    logic [31:0]    instr;
    logic [31:0]    pc;
    decoded_instr_t decoded_instr;
    logic [31:0]    wb_result;
  } mem_wb_buffer_t;

  function automatic decoded_instr_t create_nop_ctrl();
    create_nop_ctrl = '0;
  endfunction
endpackage

module rv32_mem_stage
  import rv32_mem_pkg::*;
#(
  parameter int RESP_HOLD_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  exec_mem_buffer_t exec_mem_buff,
  input  logic             stop,
  output logic             stall_req,
  output logic             mem_fault,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [31:0]      dmem_addr,
  output logic [3:0]       dmem_be,
  output logic [31:0]      dmem_wdata,
  input  logic             dmem_gnt,
  input  logic             dmem_rvalid,
  input  logic [31:0]      dmem_rdata,
  output mem_wb_buffer_t   mem_wb_buff,
  output logic [31:0]      wb_bypass
);

  typedef enum logic [1:0] {IDLE, WAIT_RESP, HOLD} state_t;

  state_t      state, state_nxt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [1:0]  addr_lo;
  logic        is_load, is_store, is_mem, legal, fault, mem_op;
  logic [31:0] shifted, load_data, held_result, complete_data;
  logic        req, stall, capture;

  assign opcode   = exec_mem_buff.instr[6:0];
  assign funct3   = exec_mem_buff.instr[14:12];
  assign addr_lo  = exec_mem_buff.mem_addr[1:0];
  assign is_load  = (opcode == 7'b0000011);
  assign is_store = (opcode == 7'b0100011);
  assign is_mem   = is_load | is_store;

  always_comb begin
    legal = 1'b0;
    case (funct3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = !addr_lo[0];
      3'b010:  legal = (addr_lo == 2'b00);
      3'b100:  legal = is_load;
      3'b101:  legal = is_load && !addr_lo[0];
      default: legal = 1'b0;
    endcase
  end

  assign fault  = is_mem && !legal;
  assign mem_op = is_mem && legal;

  // Lane steering only depends on size; loads reuse the same byte enables.
  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = exec_mem_buff.wb_result;
    case (funct3[1:0])
      2'b00: begin
        dmem_be    = 4'b0001 << addr_lo;
        dmem_wdata = {4{exec_mem_buff.wb_result[7:0]}};
      end
      2'b01: begin
        dmem_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {2{exec_mem_buff.wb_result[15:0]}};
      end
      default: begin
        dmem_be    = 4'b1111;
        dmem_wdata = exec_mem_buff.wb_result;
      end
    endcase
  end

  assign dmem_addr = {exec_mem_buff.mem_addr[31:2], 2'b00};
  assign dmem_we   = is_store;

  always_comb begin
    shifted = dmem_rdata >> {addr_lo, 3'b000};
    case (funct3)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = dmem_rdata;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    req           = 1'b0;
    stall         = 1'b0;
    capture       = 1'b0;
    complete_data = exec_mem_buff.wb_result;
    case (state)
      IDLE: begin
        if (fault) complete_data = 32'd0;
        if (mem_op && !stop) begin
          req = 1'b1;
          if (!dmem_gnt) begin
            stall = 1'b1;
          end else if (is_load) begin
            stall     = 1'b1;
            state_nxt = WAIT_RESP;
          end
        end else if (mem_op) begin
          stall = 1'b1;
        end
      end
      WAIT_RESP: begin
        stall = 1'b1;
        if (dmem_rvalid) begin
          if (!stop || RESP_HOLD_EN == 0) begin
            stall         = 1'b0;
            complete_data = load_data;
            state_nxt     = IDLE;
          end else begin
            capture   = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        stall = 1'b1;
        if (!stop) begin
          stall         = 1'b0;
          complete_data = held_result;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dmem_req  = req && !reset;
  assign mem_fault = (state == IDLE) && fault && !stop && !reset;
  assign stall_req = stall;
  assign wb_bypass = mem_wb_buff.wb_result;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      held_result <= 32'd0;
      mem_wb_buff <= '{instr: RV_NOP, pc: 32'd0, decoded_instr: create_nop_ctrl(), wb_result: 32'd0};
    end else begin
      state <= state_nxt;
      if (capture) held_result <= load_data;
      // A stalled cycle emits a bubble so the held instruction retires exactly once.
      if (!stop) begin
        if (stall)
          mem_wb_buff <= '{instr: RV_NOP, pc: 32'd0, decoded_instr: create_nop_ctrl(), wb_result: 32'd0};
        else
          mem_wb_buff <= '{instr: exec_mem_buff.instr, pc: exec_mem_buff.pc,
                           decoded_instr: exec_mem_buff.decoded_instr, wb_result: complete_data};
      end
    end
  end

endmodule

// File: tb/tb_rv32_mem_stage.sv
// Bench for rv32_mem_stage: retirements are scored against a queue of expected mem_wb entries.
module tb_rv32_mem_stage;
  import rv32_mem_pkg::*;

  localparam decoded_instr_t TB_CTRL = '{rd: 5'd5, reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b0};
  localparam logic [31:0] I_ADD = 32'h0020_81B3;
  localparam logic [31:0] I_SB  = 32'h0020_8023;
  localparam logic [31:0] I_SH  = 32'h0020_9023;
  localparam logic [31:0] I_SW  = 32'h0020_A023;
  localparam logic [31:0] I_SBU = 32'h0020_C023;
  localparam logic [31:0] I_LB  = 32'h0000_8283;
  localparam logic [31:0] I_LH  = 32'h0000_9283;
  localparam logic [31:0] I_LW  = 32'h0000_A283;
  localparam logic [31:0] I_LBU = 32'h0000_C283;

  logic             clk = 1'b0;
  logic             reset;
  exec_mem_buffer_t exec_mem_buff;
  logic             stop;
  logic             stall_req, mem_fault;
  logic             dmem_req, dmem_we;
  logic [31:0]      dmem_addr, dmem_wdata;
  logic [3:0]       dmem_be;
  logic             dmem_gnt, dmem_rvalid;
  logic [31:0]      dmem_rdata;
  mem_wb_buffer_t   mem_wb_buff;
  logic [31:0]      wb_bypass;

  int n_checks = 0;
  int n_fail   = 0;
  mem_wb_buffer_t exp_q[$];
  mem_wb_buffer_t mon_exp;
  logic mon_rst, mon_stop;

  rv32_mem_stage #(.RESP_HOLD_EN(1)) dut (
    .clk(clk), .reset(reset), .exec_mem_buff(exec_mem_buff), .stop(stop),
    .stall_req(stall_req), .mem_fault(mem_fault),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .mem_wb_buff(mem_wb_buff), .wb_bypass(wb_bypass)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every real (non-NOP) retirement must match the next queued entry.
  always @(posedge clk) begin
    mon_rst  = reset;
    mon_stop = stop;
    #1;
    if (!mon_rst && !mon_stop && mem_wb_buff.instr !== RV_NOP) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got instr %h wb %h, none expected", mem_wb_buff.instr, mem_wb_buff.wb_result);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mem_wb_buff !== mon_exp) begin
          n_fail++;
          $display("FAIL sb_retire: got instr %h pc %h wb %h, want instr %h pc %h wb %h",
                   mem_wb_buff.instr, mem_wb_buff.pc, mem_wb_buff.wb_result,
                   mon_exp.instr, mon_exp.pc, mon_exp.wb_result);
        end
      end
    end
  end

  task automatic set_exec(input logic [31:0] instr, input logic [31:0] pc,
                          input logic [31:0] addr, input logic [31:0] data);
    exec_mem_buff = '{instr: instr, pc: pc, decoded_instr: TB_CTRL, mem_addr: addr, wb_result: data};
  endtask

  task automatic set_idle();
    exec_mem_buff = '{instr: RV_NOP, pc: 32'd0, decoded_instr: create_nop_ctrl(), mem_addr: 32'd0, wb_result: 32'd0};
  endtask

  task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] wb);
    exp_q.push_back('{instr: instr, pc: pc, decoded_instr: TB_CTRL, wb_result: wb});
  endtask

  task automatic test_reset();
    reset = 1'b1; stop = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (mem_wb_buff.instr !== RV_NOP) begin n_fail++; $display("FAIL rst_instr: got %h want %h", mem_wb_buff.instr, RV_NOP); end
    n_checks++; if (mem_wb_buff.pc !== 32'd0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", mem_wb_buff.pc); end
    n_checks++; if (mem_wb_buff.decoded_instr !== create_nop_ctrl()) begin n_fail++; $display("FAIL rst_ctrl: got %h want 0", mem_wb_buff.decoded_instr); end
    n_checks++; if (wb_bypass !== 32'd0) begin n_fail++; $display("FAIL rst_bypass: got %h want 0", wb_bypass); end
    n_checks++; if (dmem_req !== 1'b0 || mem_fault !== 1'b0) begin n_fail++; $display("FAIL rst_req_fault: got %b%b want 00", dmem_req, mem_fault); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", stall_req); end
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    set_exec(I_ADD, 32'h40, 32'h0, 32'h1234);
    push_exp(I_ADD, 32'h40, 32'h1234);
    #1;
    n_checks++; if (dmem_req !== 1'b0 || stall_req !== 1'b0) begin n_fail++; $display("FAIL add_req_stall: got %b%b want 00", dmem_req, stall_req); end
    @(posedge clk); #1;
    n_checks++; if (wb_bypass !== 32'h1234) begin n_fail++; $display("FAIL add_bypass: got %h want 00001234", wb_bypass); end
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_store_wait();
    logic exp_stall;
    @(negedge clk);
    set_exec(I_SB, 32'h44, 32'h103, 32'h0000_00AB);
    push_exp(I_SB, 32'h44, 32'h0000_00AB);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      dmem_gnt  = (i == 2);
      exp_stall = (i < 2);
      #1;
      n_checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin n_fail++; $display("FAIL sb_req[%0d]: got req %b we %b want 1 1", i, dmem_req, dmem_we); end
      n_checks++; if (dmem_addr !== 32'h100 || dmem_be !== 4'b1000) begin n_fail++; $display("FAIL sb_addr_be[%0d]: got %h %b want 00000100 1000", i, dmem_addr, dmem_be); end
      n_checks++; if (dmem_wdata !== 32'hABAB_ABAB) begin n_fail++; $display("FAIL sb_wdata[%0d]: got %h want abababab", i, dmem_wdata); end
      n_checks++; if (stall_req !== exp_stall) begin n_fail++; $display("FAIL sb_stall[%0d]: got %b want %b", i, stall_req, exp_stall); end
      @(posedge clk); #1;
      if (i < 2) begin
        n_checks++; if (mem_wb_buff.instr !== RV_NOP || mem_wb_buff.wb_result !== 32'd0) begin n_fail++; $display("FAIL sb_bubble[%0d]: got %h/%h want NOP/0", i, mem_wb_buff.instr, mem_wb_buff.wb_result); end
      end
    end
    @(negedge clk);
    dmem_gnt = 1'b1;
    set_exec(I_SH, 32'h48, 32'h102, 32'h0000_1234);
    push_exp(I_SH, 32'h48, 32'h0000_1234);
    #1;
    n_checks++; if (dmem_be !== 4'b1100 || dmem_wdata !== 32'h1234_1234) begin n_fail++; $display("FAIL sh_lanes: got %b %h want 1100 12341234", dmem_be, dmem_wdata); end
    n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL sh_stall: got %b want 0", stall_req); end
    @(negedge clk);
    dmem_gnt = 1'b0;
    set_idle();
    #1;
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req: got %b want 0", dmem_req); end
  endtask

  task automatic test_load_ext();
    logic [31:0] ins [2];
    logic [31:0] want [2];
    ins  = '{I_LB, I_LBU};
    want = '{32'hFFFF_FF80, 32'h0000_0080};
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      set_exec(ins[k], 32'h50 + 32'(k * 4), 32'h102, 32'h5555_5555);
      push_exp(ins[k], 32'h50 + 32'(k * 4), want[k]);
      dmem_gnt = 1'b1;
      #1;
      n_checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || stall_req !== 1'b1) begin n_fail++; $display("FAIL ld_issue[%0d]: got req %b we %b stall %b want 1 0 1", k, dmem_req, dmem_we, stall_req); end
      @(negedge clk);
      dmem_gnt = 1'b0;
      #1;
      n_checks++; if (dmem_req !== 1'b0 || stall_req !== 1'b1) begin n_fail++; $display("FAIL ld_wait[%0d]: got req %b stall %b want 0 1", k, dmem_req, stall_req); end
      @(negedge clk);
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h0080_0000;
      #1;
      n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL ld_done_stall[%0d]: got %b want 0", k, stall_req); end
      @(posedge clk); #1;
      n_checks++; if (wb_bypass !== want[k]) begin n_fail++; $display("FAIL ld_bypass[%0d]: got %h want %h", k, wb_bypass, want[k]); end
      @(negedge clk);
      dmem_rvalid = 1'b0;
      set_idle();
    end
  endtask

  task automatic test_load_hold();
    @(negedge clk);
    set_exec(I_LW, 32'h60, 32'h200, 32'h0);
    push_exp(I_LW, 32'h60, 32'hDEAD_BEEF);
    dmem_gnt = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      dmem_gnt    = (c == 0);
      stop        = (c >= 1 && c <= 3);
      dmem_rvalid = (c == 1);
      dmem_rdata  = (c == 1) ? 32'hDEAD_BEEF : 32'h1111_1111;
      #1;
      if (c >= 1) begin
        n_checks++; if (stall_req !== (c < 4)) begin n_fail++; $display("FAIL lw_stall[%0d]: got %b want %b", c, stall_req, (c < 4)); end
      end
      @(posedge clk); #1;
      if (c >= 1 && c <= 3) begin
        n_checks++; if (mem_wb_buff.instr !== RV_NOP || mem_wb_buff.wb_result !== 32'd0) begin n_fail++; $display("FAIL lw_held[%0d]: got %h/%h want NOP/0", c, mem_wb_buff.instr, mem_wb_buff.wb_result); end
      end
    end
    n_checks++; if (wb_bypass !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_bypass: got %h want deadbeef", wb_bypass); end
    @(negedge clk);
    stop = 1'b0;
    set_idle();
  endtask

  task automatic test_fault();
    logic [31:0] ins [3];
    logic [31:0] adr [3];
    ins = '{I_LH, I_LW, I_SBU};
    adr = '{32'h101, 32'h102, 32'h100};
    dmem_gnt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set_exec(ins[k], 32'h70 + 32'(k * 4), adr[k], 32'h9999_9999);
      push_exp(ins[k], 32'h70 + 32'(k * 4), 32'd0);
      #1;
      n_checks++; if (mem_fault !== 1'b1 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL flt_sig[%0d]: got fault %b req %b want 1 0", k, mem_fault, dmem_req); end
      n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL flt_stall[%0d]: got %b want 0", k, stall_req); end
    end
    @(negedge clk);
    set_idle();
    dmem_gnt = 1'b0;
    #1;
    n_checks++; if (mem_fault !== 1'b0) begin n_fail++; $display("FAIL flt_pulse_end: got %b want 0", mem_fault); end
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk);
    set_exec(I_LW, 32'h80, 32'h300, 32'h0);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    reset = 1'b1;
    #1;
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rml_req: got %b want 0", dmem_req); end
    @(negedge clk);
    reset = 1'b0;
    set_idle();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hCAFE_F00D;
    #1;
    n_checks++; if (stall_req !== 1'b0 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL rml_idle: got stall %b req %b want 0 0", stall_req, dmem_req); end
    @(posedge clk); #1;
    n_checks++; if (mem_wb_buff.instr !== RV_NOP || mem_wb_buff.wb_result !== 32'd0) begin n_fail++; $display("FAIL rml_nop: got %h/%h want NOP/0", mem_wb_buff.instr, mem_wb_buff.wb_result); end
    @(negedge clk);
    dmem_rvalid = 1'b0;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    dmem_gnt = 1'b1;
    set_exec(I_ADD, 32'h90, 32'h0, 32'h0000_0011);
    push_exp(I_ADD, 32'h90, 32'h0000_0011);
    @(negedge clk);
    set_exec(I_SW, 32'h94, 32'h104, 32'h7654_3210);
    push_exp(I_SW, 32'h94, 32'h7654_3210);
    #1;
    n_checks++; if (dmem_be !== 4'b1111 || dmem_wdata !== 32'h7654_3210 || dmem_addr !== 32'h104) begin n_fail++; $display("FAIL sw_fields: got %b %h %h want 1111 76543210 00000104", dmem_be, dmem_wdata, dmem_addr); end
    @(negedge clk);
    set_exec(I_ADD, 32'h98, 32'h0, 32'h0000_0022);
    push_exp(I_ADD, 32'h98, 32'h0000_0022);
    @(negedge clk);
    set_idle();
    dmem_gnt = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_store_wait();
    test_load_ext();
    test_load_hold();
    test_fault();
    test_reset_mid_load();
    test_back_to_back();
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
